// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 32x32 (low word) multiply sequenced on the shared ALU via req/gnt.
// Optional MULT_EARLY_TERM_EN skips zero multiplier bits and stops once no set bits remain.
module alu_mult_sequencer #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          SHAMT_WIDTH = 5,
  parameter logic [3:0]  ALU_ADD     = 4'b0011,
  parameter logic [3:0]  ALU_SLL     = 4'b0111
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [DATA_WIDTH-1:0]  multiplicand_i,
  input  logic [DATA_WIDTH-1:0]  multiplier_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  product_o,
  output logic                   alu_req_o,
  input  logic                   alu_gnt_i,
  output logic [3:0]             alu_op_o,
  output logic [DATA_WIDTH-1:0]  alu_a_o,
  output logic [DATA_WIDTH-1:0]  alu_b_o,
  output logic [SHAMT_WIDTH-1:0] alu_shamt_o,
  input  logic [DATA_WIDTH-1:0]  alu_result_i
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ADD} state_t;

  localparam logic [SHAMT_WIDTH-1:0] LAST_IDX = SHAMT_WIDTH'(DATA_WIDTH-1);

  state_t                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  partial_q, partial_d;
  logic [DATA_WIDTH-1:0]  mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]  mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0]  product_q, product_d;
  logic                   done_q, done_d;
  logic                   add_finish;
`ifdef MULT_EARLY_TERM_EN
  // rem_q mirrors mplier >> idx so the remaining work is visible without a shifter.
  logic [DATA_WIDTH-1:0]  rem_q, rem_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      partial_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      partial_q <= partial_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef MULT_EARLY_TERM_EN
      rem_q     <= rem_d;
`endif
    end
  end

`ifdef MULT_EARLY_TERM_EN
  assign add_finish = (idx_q == LAST_IDX) || ((rem_q >> 1) == '0);
`else
  assign add_finish = (idx_q == LAST_IDX);
`endif

  // ALU drive is decoded purely from registered state so it is stable all cycle.
  always_comb begin
    alu_req_o   = 1'b0;
    alu_op_o    = '0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_shamt_o = '0;
    case (state_q)
      S_SHIFT: begin
`ifdef MULT_EARLY_TERM_EN
        if (rem_q[0]) begin
`else
        begin
`endif
          alu_req_o   = 1'b1;
          alu_op_o    = ALU_SLL;
          alu_b_o     = mcand_q;
          alu_shamt_o = idx_q;
        end
      end
      S_ADD: begin
        alu_req_o = 1'b1;
        alu_op_o  = ALU_ADD;
        alu_a_o   = acc_q;
        alu_b_o   = mplier_q[idx_q] ? partial_q : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    partial_d = partial_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    done_d    = 1'b0;
`ifdef MULT_EARLY_TERM_EN
    rem_d     = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = multiplicand_i;
          mplier_d = multiplier_i;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = S_SHIFT;
`ifdef MULT_EARLY_TERM_EN
          rem_d    = multiplier_i;
`endif
        end
      end
      S_SHIFT: begin
`ifdef MULT_EARLY_TERM_EN
        if (rem_q == '0) begin
          product_d = acc_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (!rem_q[0]) begin
          idx_d = idx_q + 1'b1;
          rem_d = rem_q >> 1;
        end else if (alu_gnt_i) begin
          partial_d = alu_result_i;
          state_d   = S_ADD;
        end
`else
        if (alu_gnt_i) begin
          partial_d = alu_result_i;
          state_d   = S_ADD;
        end
`endif
      end
      S_ADD: begin
        if (alu_gnt_i) begin
          acc_d = alu_result_i;
          if (add_finish) begin
            product_d = alu_result_i;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SHIFT;
`ifdef MULT_EARLY_TERM_EN
            rem_d   = rem_q >> 1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural ALU (add / sll).
module tb_alu_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy, done;
  logic [31:0] product;
  logic        alu_req;
  logic        alu_gnt = 1'b1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    if (alu_op == 4'b0011)      alu_result = alu_a + alu_b;
    else if (alu_op == 4'b0111) alu_result = alu_b << alu_shamt;
  end

  alu_mult_sequencer dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .multiplicand_i(multiplicand), .multiplier_i(multiplier),
    .busy_o(busy), .done_o(done), .product_o(product),
    .alu_req_o(alu_req), .alu_gnt_i(alu_gnt), .alu_op_o(alu_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_shamt_o(alu_shamt),
    .alu_result_i(alu_result)
  );

  int c_pass = 0;
  int c_total = 0;

  int lat, busy_cnt, denied;
  logic stab_ok, done_seen, prev_den;
  logic [31:0] prod_seen;
  logic [73:0] saved;
  logic req0;
  logic [3:0] op0, op1;
  logic [31:0] b0, a1, b1;
  logic [4:0] sh0;

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    c_total++;
    assert (obs === exp) c_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Caller sits just after a clock edge; operands/start are applied for the next edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int alt,
                        input int pulse_at, input int abort_at);
    multiplicand = a; multiplier = b; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0; denied = 0; stab_ok = 1'b1; done_seen = 1'b0; prev_den = 1'b0;
    while (1) begin
      if (prev_den && ({alu_req, alu_op, alu_a, alu_b, alu_shamt} !== saved)) stab_ok = 1'b0;
      if (done) begin done_seen = 1'b1; prod_seen = product; break; end
      if (lat == abort_at || lat >= 300) break;
      if (busy) busy_cnt++;
      if (lat == 0) begin req0 = alu_req; op0 = alu_op; b0 = alu_b; sh0 = alu_shamt; end
      if (lat == 1) begin op1 = alu_op; a1 = alu_a; b1 = alu_b; end
      if (lat == pulse_at) begin start = 1'b1; multiplicand = 32'd3; multiplier = 32'd3; end
      else start = 1'b0;
      if (alt != 0) alu_gnt = lat[0];
      prev_den = alu_req && !alu_gnt;
      if (prev_den) denied++;
      saved = {alu_req, alu_op, alu_a, alu_b, alu_shamt};
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 74'(busy), 74'd0);
    chk("rst_outs", {done, product, alu_req, alu_op, alu_a[4:0], alu_shamt}, 74'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 74'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 7*6 with grant tied high
    run_op(32'd7, 32'd6, 0, -1, -1);
    chk("t1_done_seen", 74'(done_seen), 74'd1);
    chk("t1_product", 74'(prod_seen), 74'd42);
    chk("t1_shift_drive", {req0, op0, b0, sh0}, {1'b1, 4'b0111, 32'd7, 5'd0});
    chk("t1_add0_drive", {op1, a1, b1}, {4'b0011, 32'd0, 32'd0});
`ifndef MULT_EARLY_TERM_EN
    chk("t1_latency", 74'(lat), 74'd64);
    chk("t1_busy_cycles", 74'(busy_cnt), 74'd64);
`endif
    chk("t1_busy_in_done", 74'(busy), 74'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 74'(done), 74'd0);
    chk("t1_product_hold", 74'(product), 74'd42);

    // wraparound cases
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, -1);
    chk("t2_all_ones", 74'(prod_seen), 74'd1);
    @(posedge clk); #1;
    run_op(32'h0001_0000, 32'h0001_0000, 0, -1, -1);
    chk("t2_wrap_zero", 74'(prod_seen), 74'd0);
    chk("t2_done_seen", 74'(done_seen), 74'd1);
    @(posedge clk); #1;

    // 13*11 with alternating grant
    run_op(32'd13, 32'd11, 1, -1, -1);
    chk("t3_product", 74'(prod_seen), 74'd143);
    chk("t3_some_denied", 74'(denied > 0), 74'd1);
    chk("t3_stable_denied", 74'(stab_ok), 74'd1);
`ifndef MULT_EARLY_TERM_EN
    chk("t3_latency", 74'(lat), 74'(64 + denied));
`endif
    @(posedge clk); #1;

    // start pulsed mid-operation is ignored
    run_op(32'd12, 32'd10, 0, 10, -1);
    chk("t4_ignore_product", 74'(prod_seen), 74'd120);
`ifndef MULT_EARLY_TERM_EN
    chk("t4_ignore_latency", 74'(lat), 74'd64);
`endif
    @(posedge clk); #1;
    chk("t4_no_relaunch", 74'(busy), 74'd0);

    // back-to-back: second start issued in the done cycle
    run_op(32'd5, 32'd5, 0, -1, -1);
    chk("t4_first", 74'(prod_seen), 74'd25);
    run_op(32'd2, 32'd3, 0, -1, -1);
    chk("t4_b2b_product", 74'(prod_seen), 74'd6);
`ifndef MULT_EARLY_TERM_EN
    chk("t4_b2b_latency", 74'(lat), 74'd64);
`endif
    @(posedge clk); #1;

    // reset 20 clocks into 9*9
    run_op(32'd9, 32'd9, 0, -1, 20);
    chk("t5_no_done_before", 74'(done_seen), 74'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy", 74'(busy), 74'd0);
    chk("t5_outs", {done, product, alu_req, alu_op, alu_shamt}, 74'd0);
    chk("t5_alu_ab", {alu_a, alu_b}, 74'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done_after", {busy, done}, 74'd0);
    run_op(32'd9, 32'd9, 0, -1, -1);
    chk("t5_rerun", 74'(prod_seen), 74'd81);
    @(posedge clk); #1;

`ifdef MULT_EARLY_TERM_EN
    run_op(32'd5, 32'd0, 0, -1, -1);
    chk("t6_zero_product", 74'(prod_seen), 74'd0);
    chk("t6_zero_latency", 74'(lat), 74'd1);
    @(posedge clk); #1;
    run_op(32'd3, 32'd4, 0, -1, -1);
    chk("t6_skip_product", 74'(prod_seen), 74'd12);
    chk("t6_skip_latency", 74'(lat), 74'd4);
    chk("t6_skip_noreq", 74'(req0), 74'd0);
`endif

    $display("%0d/%0d checks passed", c_pass, c_total);
    $finish;
  end

endmodule
